param_sdp_ram: RTL and testbench
================================

Name: param_sdp_ram

Overview:
- Parametrised simple-dual-port synchronous RAM; successor to the single-port 32-bit word RAM used as CPU/peripheral scratch memory.
- Adds:
  - independent read and write ports
  - byte-lane write strobes
  - selectable read latency
  - selectable read-during-write policy
  - out-of-range detection
  - a hardware clear sequencer that zeroes the array after reset or on request.
- Sits between the core's load/store unit and peripheral buffers.

Parameters:
- DATA_W, 32, word width in bits; must be a multiple of 8.
- ADDR_W, 12, address port width.
- DEPTH, 1024, number of words; DEPTH <= 2**ADDR_W.
- READ_LATENCY, 1, cycles from accepted read to rd_valid; legal values 1 or 2.
- RDW_MODE, 0, same-address same-cycle read/write: 0 = read-first (old data), 1 = write-first (new data, strobes merged).

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- clr  in  1  pulse: start array clear
- ready  out  1  high when ports accept requests (clear not running)
- wr_en  in  1  write request
- wr_addr  in  ADDR_W  write word address
- wr_strb  in  DATA_W/8  byte enables, bit i -> wr_data[8i+7:8i]
- wr_data  in  DATA_W  write data
- rd_en  in  1  read request
- rd_addr  in  ADDR_W  read word address
- rd_valid  out  1  read data valid, one-cycle pulse per accepted read
- rd_data  out  DATA_W  read data; holds its last value when rd_valid=0
- rd_oob  out  1  qualifies rd_valid: read address was >= DEPTH
- wr_oob  out  1  one-cycle pulse: accepted write had address >= DEPTH and was dropped

Behaviour:
- Reset, while rst is high:
  - ready=0, rd_valid=0, rd_data=0, rd_oob=0, wr_oob=0
  - FSM=CLEAR, clear counter=0
  - in-flight reads discarded.
- FSM states: CLEAR, RUN.
  - CLEAR: writes all-zero to mem[cnt] and increments cnt every cycle, one word per cycle.
  - CLEAR -> RUN at the edge that writes word DEPTH-1. ready=1 from that edge.
  - Clear duration: rst sampled high at edge E0; words 0..DEPTH-1 zeroed at edges E1..E_DEPTH; ready=1 after E_DEPTH.
  - RUN -> CLEAR when clr is sampled high with ready=1. cnt=0 and ready=0 from that edge.
  - wr_en/rd_en in the clr cycle are dropped: no write, no rd_valid.
  - clr while already in CLEAR is ignored; the sweep does not restart.
- ready is registered. Requests are accepted only on edges where ready=1. wr_en/rd_en with ready=0 are ignored, not queued.
- Accepted write:
  - addr < DEPTH: updates only lanes with wr_strb set; wr_strb=0 is a no-op.
  - addr >= DEPTH: memory untouched; wr_oob=1 for one cycle.
- Accepted read:
  - READ_LATENCY=1: rd_valid=1 in the cycle after the accept edge.
  - READ_LATENCY=2: rd_valid=1 one cycle later through an output register stage.
  - Fully pipelined: back-to-back reads each cycle give back-to-back rd_valid.
  - addr >= DEPTH: rd_data=0, rd_oob=1 with rd_valid.
- Read-during-write, same address in the same accept cycle, per RDW_MODE:
  - RDW_MODE=0: rd_data = previous word.
  - RDW_MODE=1: rd_data = per byte, new lane if strobe set, else old lane.
  - Different addresses: independent, no interaction.
- A read accepted the cycle after a write to the same address always returns the written data.
- rst mid-read: pending rd_valid pulses are suppressed; clear restarts from word 0.
- clr while reads are in flight: in-flight reads complete with pre-clear data; the clear begins at the clr edge.
- The array itself is not reset other than by the clear sweep.

Test Plan:
- DEPTH=16, rst pulse one cycle -> ready rises exactly 16 cycles after rst falls; subsequent reads of addr 0..15 all return 0.
- Write 0xDEADBEEF to addr 5 (strb 0xF), then write 0x000000AA to addr 5 with strb 0x1, read addr 5 -> rd_data=0xDEADBEAA; rd_valid 1 cycle after accept (LAT=1), 2 cycles (LAT=2).
- Same cycle wr addr 3 data 0x11111111 strb 0xF, rd addr 3, old word 0x22222222 -> RDW_MODE=0 returns 0x22222222; RDW_MODE=1 returns 0x11111111.
- DEPTH=1000, ADDR_W=12: write addr 1000 -> wr_oob pulse, memory unchanged; read addr 1023 -> rd_valid=1, rd_oob=1, rd_data=0.
- Reads every cycle to addrs 0..7 -> 8 consecutive rd_valid pulses with matching data, order preserved, at both latencies.
- Assert clr in the same cycle as wr_en to addr 2 -> write dropped, ready low DEPTH cycles, addr 2 reads 0; rst asserted with a read in flight -> no rd_valid emitted.

Source files
------------

// File: rtl/param_sdp_ram.sv
// param_sdp_ram: simple-dual-port RAM with byte strobes, selectable read latency/RDW policy and a clear sequencer
module param_sdp_ram #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12,
  parameter int DEPTH = 1024,
  parameter int READ_LATENCY = 1,
  parameter int RDW_MODE = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  output logic                ready,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W/8-1:0] wr_strb,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic                rd_en,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic                rd_valid,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_oob,
  output logic                wr_oob
);
  localparam int NB = DATA_W / 8;
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [0:0] CLEAR = 1'b0;
  localparam logic [0:0] RUN = 1'b1;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [0:0] state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic wr_acc, rd_acc, wr_in, rd_in, same, wr_oob_q, v1_q, o1_q;
  logic [DATA_W-1:0] old_w, new_w, rd_d, d1_q;
  assign ready = state_q == RUN;
  assign wr_acc = ready & ~rst & ~clr & wr_en;
  assign rd_acc = ready & ~rst & ~clr & rd_en;
  assign wr_in = 32'(wr_addr) < DEPTH;
  assign rd_in = 32'(rd_addr) < DEPTH;
  assign old_w = rd_in ? mem[rd_addr[AW-1:0]] : '0;
  assign same = RDW_MODE == 1 && wr_acc && wr_in && wr_addr == rd_addr;
  assign rd_d = same ? new_w : old_w;
  assign wr_oob = wr_oob_q;
  // Sweep one word per cycle in CLEAR; a clr in RUN restarts the sweep from word 0
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    if (state_q == CLEAR) begin
      cnt_d = cnt_q == AW'(DEPTH - 1) ? '0 : cnt_q + 1'b1;
      state_d = cnt_q == AW'(DEPTH - 1) ? RUN : CLEAR;
    end else if (clr) begin
      state_d = CLEAR;
      cnt_d = '0;
    end
  end
  // Write-first view of the read word: strobed lanes of the incoming write over the stored word
  always_comb begin
    new_w = old_w;
    for (int i = 0; i < NB; i++) if (wr_strb[i]) new_w[8*i+:8] = wr_data[8*i+:8];
  end
  // Control state and first read stage; read data is captured at the accept edge
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      cnt_q <= '0;
      wr_oob_q <= 1'b0;
      v1_q <= 1'b0;
      o1_q <= 1'b0;
      d1_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      wr_oob_q <= wr_acc & ~wr_in;
      v1_q <= rd_acc;
      o1_q <= rd_acc & ~rd_in;
      if (rd_acc) d1_q <= rd_d;
    end
  end
  // Storage array: cleared by the sweep, otherwise written per byte lane; never reset directly
  always_ff @(posedge clk) begin
    if (!rst && state_q == CLEAR) mem[cnt_q] <= '0;
    else if (wr_acc && wr_in)
      for (int i = 0; i < NB; i++) if (wr_strb[i]) mem[wr_addr[AW-1:0]][8*i+:8] <= wr_data[8*i+:8];
  end
  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic v2_q, o2_q;
      logic [DATA_W-1:0] d2_q;
      // Extra output register stage; data holds between valid pulses
      always_ff @(posedge clk) begin
        if (rst) begin
          v2_q <= 1'b0;
          o2_q <= 1'b0;
          d2_q <= '0;
        end else begin
          v2_q <= v1_q;
          o2_q <= o1_q;
          if (v1_q) d2_q <= d1_q;
        end
      end
      assign rd_valid = v2_q;
      assign rd_oob = o2_q;
      assign rd_data = d2_q;
    end else begin : g_lat1
      assign rd_valid = v1_q;
      assign rd_oob = o1_q;
      assign rd_data = d1_q;
    end
  endgenerate
endmodule

// File: tb/tb_param_sdp_ram.sv
// tb_param_sdp_ram: directed self-checking bench over three RAM configurations sharing one stimulus
module tb_param_sdp_ram;
  typedef struct packed {
    logic [31:0] cyc;
    logic        oob;
    logic [31:0] d;
  } ent_t;
  logic clk = 1'b0;
  logic rst, clr, wr_en, rd_en;
  logic [11:0] wr_addr, rd_addr;
  logic [3:0] wr_strb;
  logic [31:0] wr_data;
  logic [2:0] rdy, rv, ro, wo;
  logic [31:0] rdat [3];
  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int lat [3] = '{1, 2, 1};
  int rdw [3] = '{0, 1, 0};
  int dep [3] = '{16, 16, 1000};
  ent_t q0[$], q1[$], q2[$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (rv[0]) q0.push_back({32'(cyc), ro[0], rdat[0]});
    if (rv[1]) q1.push_back({32'(cyc), ro[1], rdat[1]});
    if (rv[2]) q2.push_back({32'(cyc), ro[2], rdat[2]});
  end
  param_sdp_ram #(.DEPTH(16), .READ_LATENCY(1), .RDW_MODE(0)) u0 (
    .clk(clk), .rst(rst), .clr(clr), .ready(rdy[0]), .wr_en(wr_en), .wr_addr(wr_addr), .wr_strb(wr_strb),
    .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rv[0]), .rd_data(rdat[0]), .rd_oob(ro[0]), .wr_oob(wo[0]));
  param_sdp_ram #(.DEPTH(16), .READ_LATENCY(2), .RDW_MODE(1)) u1 (
    .clk(clk), .rst(rst), .clr(clr), .ready(rdy[1]), .wr_en(wr_en), .wr_addr(wr_addr), .wr_strb(wr_strb),
    .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rv[1]), .rd_data(rdat[1]), .rd_oob(ro[1]), .wr_oob(wo[1]));
  param_sdp_ram #(.DEPTH(1000), .READ_LATENCY(1), .RDW_MODE(0)) u2 (
    .clk(clk), .rst(rst), .clr(clr), .ready(rdy[2]), .wr_en(wr_en), .wr_addr(wr_addr), .wr_strb(wr_strb),
    .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rv[2]), .rd_data(rdat[2]), .rd_oob(ro[2]), .wr_oob(wo[2]));
  function automatic int qn(input int k);
    if (k == 0) return q0.size();
    if (k == 1) return q1.size();
    return q2.size();
  endfunction
  function automatic ent_t qe(input int k, input int i);
    if (k == 0) return q0[i];
    if (k == 1) return q1[i];
    return q2[i];
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic set_wr(input int a, input logic [3:0] s, input logic [31:0] d);
    wr_en = 1'b1;
    wr_addr = 12'(a);
    wr_strb = s;
    wr_data = d;
  endtask
  task automatic set_rd(input int a);
    rd_en = 1'b1;
    rd_addr = 12'(a);
  endtask
  task automatic idle;
    wr_en = 1'b0;
    rd_en = 1'b0;
    clr = 1'b0;
  endtask
  task automatic flush;
    q0.delete();
    q1.delete();
    q2.delete();
  endtask
  task automatic test_reset;
    int t [3];
    t = '{0, 0, 0};
    idle();
    rst = 1'b1;
    wr_addr = '0;
    rd_addr = '0;
    wr_strb = '0;
    wr_data = '0;
    tick();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({rdy[k], rv[k], ro[k], wo[k], rdat[k]} !== 36'h0) begin
        failures++;
        $display("FAIL reset_state dut%0d got rdy=%b rv=%b ro=%b wo=%b rd=%h exp all zero", k, rdy[k], rv[k], ro[k], wo[k], rdat[k]);
      end
    end
    rst = 1'b0;
    for (int k = 1; k <= 1100 && t[2] == 0; k++) begin
      tick();
      for (int j = 0; j < 3; j++) if (rdy[j] && t[j] == 0) t[j] = k;
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (t[k] != dep[k]) begin
        failures++;
        $display("FAIL reset_ready_delay dut%0d got=%0d exp=%0d", k, t[k], dep[k]);
      end
    end
  endtask
  task automatic test_clear_zero;
    int acc;
    ent_t e;
    flush();
    for (int a = 0; a < 16; a++) begin
      set_rd(a);
      tick();
      if (a == 0) acc = cyc;
    end
    idle();
    repeat (4) tick();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (qn(k) != 16) begin
        failures++;
        $display("FAIL zero_count dut%0d got=%0d exp=16", k, qn(k));
      end else for (int i = 0; i < 16; i++) begin
        e = qe(k, i);
        checks++;
        if ({e.cyc, e.oob, e.d} !== {32'(acc + lat[k] - 1 + i), 1'b0, 32'h0}) begin
          failures++;
          $display("FAIL zero_read dut%0d idx%0d got cyc=%0d oob=%b d=%h exp cyc=%0d oob=0 d=0", k, i, e.cyc, e.oob, e.d, acc + lat[k] - 1 + i);
        end
      end
    end
  endtask
  task automatic test_strobe;
    int acc;
    ent_t e;
    flush();
    set_wr(5, 4'hF, 32'hDEADBEEF);
    tick();
    set_wr(5, 4'h1, 32'h000000AA);
    tick();
    idle();
    set_rd(5);
    tick();
    acc = cyc;
    idle();
    repeat (3) tick();
    for (int k = 0; k < 3; k++) begin
      checks++;
      e = qn(k) == 1 ? qe(k, 0) : '0;
      if (qn(k) != 1 || {e.cyc, e.oob, e.d} !== {32'(acc + lat[k] - 1), 1'b0, 32'hDEADBEAA}) begin
        failures++;
        $display("FAIL strobe_merge dut%0d got n=%0d cyc=%0d d=%h exp n=1 cyc=%0d d=deadbeaa", k, qn(k), e.cyc, e.d, acc + lat[k] - 1);
      end
    end
  endtask
  task automatic test_rdw;
    int a1;
    logic [31:0] x [3];
    ent_t e;
    flush();
    set_wr(3, 4'hF, 32'h22222222);
    tick();
    set_wr(3, 4'hF, 32'h11111111);
    set_rd(3);
    tick();
    a1 = cyc;
    set_wr(3, 4'h5, 32'h33333333);
    set_rd(3);
    tick();
    idle();
    set_rd(3);
    tick();
    idle();
    repeat (3) tick();
    for (int k = 0; k < 3; k++) begin
      x[0] = rdw[k] == 1 ? 32'h11111111 : 32'h22222222;
      x[1] = rdw[k] == 1 ? 32'h11331133 : 32'h11111111;
      x[2] = 32'h11331133;
      checks++;
      if (qn(k) != 3) begin
        failures++;
        $display("FAIL rdw_count dut%0d got=%0d exp=3", k, qn(k));
      end else for (int i = 0; i < 3; i++) begin
        e = qe(k, i);
        checks++;
        if ({e.cyc, e.d} !== {32'(a1 + lat[k] - 1 + i), x[i]}) begin
          failures++;
          $display("FAIL rdw_data dut%0d idx%0d got cyc=%0d d=%h exp cyc=%0d d=%h", k, i, e.cyc, e.d, a1 + lat[k] - 1 + i, x[i]);
        end
      end
    end
  endtask
  task automatic test_oob;
    logic [32:0] x [4];
    ent_t e;
    flush();
    set_wr(999, 4'hF, 32'h12345678);
    tick();
    checks++;
    if (wo !== 3'b011) begin
      failures++;
      $display("FAIL wr_oob_999 got=%b exp=011", wo);
    end
    set_wr(1000, 4'hF, 32'hFFFFFFFF);
    tick();
    checks++;
    if (wo !== 3'b111) begin
      failures++;
      $display("FAIL wr_oob_1000 got=%b exp=111", wo);
    end
    idle();
    tick();
    checks++;
    if (wo !== 3'b000) begin
      failures++;
      $display("FAIL wr_oob_pulse got=%b exp=000", wo);
    end
    set_rd(999);
    tick();
    set_rd(1023);
    tick();
    set_rd(8);
    tick();
    set_rd(7);
    tick();
    idle();
    repeat (3) tick();
    for (int k = 0; k < 3; k++) begin
      x[0] = k == 2 ? {1'b0, 32'h12345678} : {1'b1, 32'h0};
      x[1] = {1'b1, 32'h0};
      x[2] = 33'h0;
      x[3] = 33'h0;
      checks++;
      if (qn(k) != 4) begin
        failures++;
        $display("FAIL oob_count dut%0d got=%0d exp=4", k, qn(k));
      end else for (int i = 0; i < 4; i++) begin
        e = qe(k, i);
        checks++;
        if ({e.oob, e.d} !== x[i]) begin
          failures++;
          $display("FAIL oob_read dut%0d idx%0d got oob=%b d=%h exp oob=%b d=%h", k, i, e.oob, e.d, x[i][32], x[i][31:0]);
        end
      end
    end
  endtask
  task automatic test_back_to_back;
    int acc;
    ent_t e;
    flush();
    for (int a = 0; a < 8; a++) begin
      set_wr(a, 4'hF, 32'h01010101 * 32'(a + 1));
      tick();
    end
    idle();
    for (int a = 0; a < 8; a++) begin
      set_rd(a);
      tick();
      if (a == 0) acc = cyc;
    end
    idle();
    repeat (3) tick();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (qn(k) != 8) begin
        failures++;
        $display("FAIL b2b_count dut%0d got=%0d exp=8", k, qn(k));
      end else for (int i = 0; i < 8; i++) begin
        e = qe(k, i);
        checks++;
        if ({e.cyc, e.oob, e.d} !== {32'(acc + lat[k] - 1 + i), 1'b0, 32'h01010101 * 32'(i + 1)}) begin
          failures++;
          $display("FAIL b2b_read dut%0d idx%0d got cyc=%0d d=%h exp cyc=%0d d=%h", k, i, e.cyc, e.d, acc + lat[k] - 1 + i, 32'h01010101 * 32'(i + 1));
        end
      end
    end
  endtask
  task automatic test_clr;
    int ac;
    int t [3];
    ent_t e;
    t = '{0, 0, 0};
    flush();
    set_rd(1);
    tick();
    ac = cyc;
    idle();
    clr = 1'b1;
    set_wr(2, 4'hF, 32'hCAFEF00D);
    set_rd(0);
    tick();
    checks++;
    if (rdy !== 3'b000 || wo !== 3'b000) begin
      failures++;
      $display("FAIL clr_edge got rdy=%b wo=%b exp rdy=000 wo=000", rdy, wo);
    end
    idle();
    for (int k = 1; k <= 1100 && t[2] == 0; k++) begin
      clr = k == 5;
      tick();
      for (int j = 0; j < 3; j++) if (rdy[j] && t[j] == 0) t[j] = k;
    end
    clr = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (t[k] != dep[k]) begin
        failures++;
        $display("FAIL clr_ready_delay dut%0d got=%0d exp=%0d", k, t[k], dep[k]);
      end
      e = qn(k) == 1 ? qe(k, 0) : '0;
      checks++;
      if (qn(k) != 1 || {e.cyc, e.d} !== {32'(ac + lat[k] - 1), 32'h02020202}) begin
        failures++;
        $display("FAIL clr_inflight dut%0d got n=%0d cyc=%0d d=%h exp n=1 cyc=%0d d=02020202", k, qn(k), e.cyc, e.d, ac + lat[k] - 1);
      end
    end
    flush();
    set_rd(2);
    tick();
    set_rd(1);
    tick();
    idle();
    repeat (3) tick();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (qn(k) != 2 || qe(k, 0).d !== 32'h0 || qe(k, 1).d !== 32'h0) begin
        failures++;
        $display("FAIL clr_zeroed dut%0d got n=%0d exp n=2 with zero data", k, qn(k));
      end
    end
  endtask
  task automatic test_rst_inflight;
    flush();
    set_rd(4);
    tick();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (3) tick();
    checks++;
    if (qn(0) != 1 || qn(1) != 0 || qn(2) != 1) begin
      failures++;
      $display("FAIL rst_inflight got n=%0d/%0d/%0d exp 1/0/1", qn(0), qn(1), qn(2));
    end
    checks++;
    if (rdy !== 3'b000) begin
      failures++;
      $display("FAIL rst_ready got=%b exp=000", rdy);
    end
  endtask
  initial begin
    test_reset();
    test_clear_zero();
    test_strobe();
    test_rdw();
    test_oob();
    test_back_to_back();
    test_clr();
    test_rst_inflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
